// File: rtl/countdown_scheduler_if.sv
// rtl/countdown_scheduler_if.sv - requester/scheduler signal bundle for the shared countdown timer
interface countdown_scheduler_if #(
  parameter int WIDTH = 8
) ();
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;
  logic [WIDTH-1:0] cnt;

  modport master (
    output req0, req1, len0, len1,
    input  gnt0, gnt1, done0, done1, busy, cnt
  );

  modport slave (
    input  req0, req1, len0, len1,
    output gnt0, gnt1, done0, done1, busy, cnt
  );
endinterface

// File: rtl/countdown_scheduler.sv
// rtl/countdown_scheduler.sv - round-robin arbiter sharing one down-counter between two requesters
module countdown_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  countdown_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic             gnt0, gnt0_n;
  logic             gnt1, gnt1_n;
  logic             done0, done0_n;
  logic             done1, done1_n;
  logic             sel, sel_n;    // index of the requester currently being served
  logic             last, last_n;  // index of the requester served most recently
  logic             greq;          // request line of the granted requester
  logic [WIDTH-1:0] glen;          // length of the granted requester

  assign greq = sel ? bus.req1 : bus.req0;
  assign glen = sel ? bus.len1 : bus.len0;

  // State and registered outputs; reset makes requester 1 "last served" so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      sel   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gnt0  <= gnt0_n;
      gnt1  <= gnt1_n;
      done0 <= done0_n;
      done1 <= done1_n;
      sel   <= sel_n;
      last  <= last_n;
    end
  end

  // Next-state logic: arbitrate in IDLE, load, count down, pulse done; abort if the grant holder lets go
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt0_n  = gnt0;
    gnt1_n  = gnt1;
    done0_n = 1'b0;
    done1_n = 1'b0;
    sel_n   = sel;
    last_n  = last;

    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Contention goes to whoever was not served last; a lone request simply wins
          sel_n   = (bus.req0 && bus.req1) ? ~last : bus.req1;
          gnt0_n  = ~sel_n;
          gnt1_n  = sel_n;
          state_n = LOAD;
        end
      end

      LOAD: begin
        if (!greq) begin
          state_n = IDLE;
          gnt0_n  = 1'b0;
          gnt1_n  = 1'b0;
          cnt_n   = '0;
          last_n  = sel;
        end else begin
          cnt_n = glen;
          if (glen == '0) begin
            state_n = DONE;
            done0_n = ~sel;
            done1_n = sel;
          end else begin
            state_n = COUNT;
          end
        end
      end

      COUNT: begin
        if (!greq) begin
          state_n = IDLE;
          gnt0_n  = 1'b0;
          gnt1_n  = 1'b0;
          cnt_n   = '0;
          last_n  = sel;
        end else if (cnt <= WIDTH'(1)) begin
          // Final decrement lands on zero as DONE is entered; a zero count never wraps
          cnt_n   = '0;
          state_n = DONE;
          done0_n = ~sel;
          done1_n = sel;
        end else begin
          cnt_n = cnt - WIDTH'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        cnt_n   = '0;
        last_n  = sel;
      end

      default: begin
        state_n = IDLE;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.gnt0  = gnt0;
  assign bus.gnt1  = gnt1;
  assign bus.done0 = done0;
  assign bus.done1 = done1;
  assign bus.busy  = (state != IDLE);
  assign bus.cnt   = cnt;

endmodule

// File: tb/tb_countdown_scheduler.sv
// tb/tb_countdown_scheduler.sv - directed self-checking bench for countdown_scheduler
module tb_countdown_scheduler;
  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  countdown_scheduler_if #(.WIDTH(WIDTH)) bus ();

  countdown_scheduler #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.len0 = '0; bus.len1 = '0;
    repeat (3) tick();
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 00000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy});
    end
    tests++;
    if (bus.cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_cnt: got %0d expected 0", bus.cnt);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    tests++;
    if ({bus.busy, bus.gnt0, bus.gnt1} !== 3'b0) begin
      fails++;
      $display("FAIL idle_no_req: got %b expected 000", {bus.busy, bus.gnt0, bus.gnt1});
    end
  endtask

  task automatic test_single();
    bus.req0 = 1'b1; bus.len0 = 8'd5;
    tick();
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b101) begin
      fails++;
      $display("FAIL single_grant: got %b expected 101", {bus.gnt0, bus.gnt1, bus.busy});
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (bus.cnt !== 8'(5 - k) || bus.done0 !== 1'b0) begin
        fails++;
        $display("FAIL single_count k=%0d: got cnt %0d done0 %b expected cnt %0d done0 0", k, bus.cnt, bus.done0, 5 - k);
      end
    end
    tick();
    tests++;
    if (bus.cnt !== 8'd0 || bus.done0 !== 1'b1 || bus.gnt0 !== 1'b1) begin
      fails++;
      $display("FAIL single_done: got cnt %0d done0 %b gnt0 %b expected 0 1 1", bus.cnt, bus.done0, bus.gnt0);
    end
    bus.req0 = 1'b0;
    tick();
    tests++;
    if ({bus.gnt0, bus.done0, bus.busy} !== 3'b000) begin
      fails++;
      $display("FAIL single_idle: got %b expected 000", {bus.gnt0, bus.done0, bus.busy});
    end
  endtask

  task automatic test_contention();
    int n;
    bit w;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.len0 = 8'd3; bus.len1 = 8'd2;
    for (int r = 0; r < 3; r++) begin
      w = (r == 1);
      n = w ? 2 : 3;
      tick();
      tests++;
      if (bus.gnt0 !== !w || bus.gnt1 !== w) begin
        fails++;
        $display("FAIL rr_grant round %0d: got gnt0 %b gnt1 %b expected %b %b", r, bus.gnt0, bus.gnt1, !w, w);
      end
      for (int c = 1; c <= n + 2; c++) begin
        tick();
        tests++;
        if (bus.done0 !== (!w && c == n + 1) || bus.done1 !== (w && c == n + 1) ||
            (bus.gnt0 && bus.gnt1) || bus.cnt !== 8'((c <= n) ? n - c + 1 : 0)) begin
          fails++;
          $display("FAIL rr_service round %0d c=%0d: got done %b%b gnt %b%b cnt %0d expected done %b%b cnt %0d",
                   r, c, bus.done0, bus.done1, bus.gnt0, bus.gnt1, bus.cnt,
                   (!w && c == n + 1), (w && c == n + 1), (c <= n) ? n - c + 1 : 0);
        end
      end
      tests++;
      if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b000) begin
        fails++;
        $display("FAIL rr_idle round %0d: got %b expected 000", r, {bus.gnt0, bus.gnt1, bus.busy});
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_len_zero();
    bus.req1 = 1'b1; bus.len1 = 8'd0;
    tick();
    tests++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
      fails++;
      $display("FAIL len0_grant: got gnt0 %b gnt1 %b expected 0 1", bus.gnt0, bus.gnt1);
    end
    tick();
    tests++;
    if (bus.done1 !== 1'b1 || bus.cnt !== 8'd0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL len0_done: got done1 %b cnt %0d busy %b expected 1 0 1", bus.done1, bus.cnt, bus.busy);
    end
    bus.req1 = 1'b0;
    tick();
    tests++;
    if ({bus.gnt1, bus.done1, bus.busy} !== 3'b000) begin
      fails++;
      $display("FAIL len0_idle: got %b expected 000", {bus.gnt1, bus.done1, bus.busy});
    end
  endtask

  task automatic test_max_len();
    bus.req0 = 1'b1; bus.len0 = 8'd255;
    tick();
    tests++;
    if (bus.gnt0 !== 1'b1) begin
      fails++;
      $display("FAIL max_grant: got gnt0 %b expected 1", bus.gnt0);
    end
    for (int c = 1; c <= 257; c++) begin
      if (c == 3) bus.len0 = 8'd7;
      tick();
      tests++;
      if (bus.cnt !== 8'((c <= 255) ? 256 - c : 0) || bus.done0 !== (c == 256)) begin
        fails++;
        $display("FAIL max_count c=%0d: got cnt %0d done0 %b expected cnt %0d done0 %b",
                 c, bus.cnt, bus.done0, (c <= 255) ? 256 - c : 0, (c == 256));
      end
      if (c == 256) bus.req0 = 1'b0;
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL max_idle: got busy %b expected 0", bus.busy);
    end
  endtask

  task automatic test_abort();
    bus.req0 = 1'b1; bus.len0 = 8'd10; bus.req1 = 1'b0; bus.len1 = 8'd4;
    tick();
    bus.req1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      tests++;
      if (bus.cnt !== 8'(11 - c) || bus.gnt1 !== 1'b0) begin
        fails++;
        $display("FAIL abort_count c=%0d: got cnt %0d gnt1 %b expected cnt %0d gnt1 0", c, bus.cnt, bus.gnt1, 11 - c);
      end
    end
    bus.req0 = 1'b0;
    tick();
    tests++;
    if ({bus.busy, bus.gnt0, bus.done0} !== 3'b000 || bus.cnt !== 8'd0) begin
      fails++;
      $display("FAIL abort_idle: got busy/gnt0/done0 %b cnt %0d expected 000 0", {bus.busy, bus.gnt0, bus.done0}, bus.cnt);
    end
    tick();
    tests++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
      fails++;
      $display("FAIL abort_next_grant: got gnt0 %b gnt1 %b expected 0 1", bus.gnt0, bus.gnt1);
    end
    bus.req1 = 1'b0;
    tick();
    tests++;
    if ({bus.busy, bus.gnt1, bus.done1} !== 3'b000) begin
      fails++;
      $display("FAIL abort_load_idle: got %b expected 000", {bus.busy, bus.gnt1, bus.done1});
    end
  endtask

  task automatic test_async_reset();
    // Serve requester 0 once so that, absent reset, requester 1 would win the next contention
    bus.req0 = 1'b1; bus.len0 = 8'd0; bus.req1 = 1'b0;
    tick();
    tick();
    bus.req0 = 1'b0;
    tick();
    bus.req0 = 1'b1; bus.len0 = 8'd8;
    tick();
    for (int c = 1; c <= 5; c++) tick();
    tests++;
    if (bus.cnt !== 8'd4) begin
      fails++;
      $display("FAIL areset_pre_cnt: got %0d expected 4", bus.cnt);
    end
    bus.req1 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b0 || bus.cnt !== 8'd0) begin
      fails++;
      $display("FAIL areset_immediate: got %b cnt %0d expected 00000 0",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, bus.cnt);
    end
    tick();
    tick();
    tests++;
    if ({bus.done0, bus.done1, bus.busy} !== 3'b000) begin
      fails++;
      $display("FAIL areset_held: got %b expected 000", {bus.done0, bus.done1, bus.busy});
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      fails++;
      $display("FAIL areset_first_winner: got gnt0 %b gnt1 %b expected 1 0", bus.gnt0, bus.gnt1);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_len_zero();
    test_max_len();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
